// File: rtl/traffic_pkg.sv
// Shared phase encoding and sequencing helpers for the intersection controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    GR  = 3'd0,
    YR  = 3'd1,
    RR1 = 3'd2,
    RG  = 3'd3,
    RY  = 3'd4,
    RR2 = 3'd5,
    PED = 3'd6
  } phase_t;

  // Successor of a phase; RR2 branches to the walk phase when a request is latched.
  function automatic phase_t next_phase(input phase_t p, input logic ped);
    phase_t n;
    case (p)
      GR:      n = YR;
      YR:      n = RR1;
      RR1:     n = RG;
      RG:      n = RY;
      RY:      n = RR2;
      RR2:     n = ped ? PED : GR;
      default: n = GR;
    endcase
    return n;
  endfunction

  function automatic int unsigned phase_duration(
    input phase_t      p,
    input int unsigned t_green_main,
    input int unsigned t_yellow,
    input int unsigned t_allred,
    input int unsigned t_green_side,
    input int unsigned t_ped
  );
    int unsigned d;
    case (p)
      YR, RY:   d = t_yellow;
      RR1, RR2: d = t_allred;
      RG:       d = t_green_side;
      PED:      d = t_ped;
      default:  d = t_green_main;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock into a one-cycle tick every TICK_DIV cycles.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Phase sequencer: times each light phase in seconds, holds main green until
// there is side-street or pedestrian demand, and latches walk requests.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50000000,
  parameter int unsigned CNT_W        = 6,
  parameter int unsigned T_GREEN_MAIN = 20,
  parameter int unsigned T_YELLOW     = 3,
  parameter int unsigned T_ALLRED     = 1,
  parameter int unsigned T_GREEN_SIDE = 10,
  parameter int unsigned T_PED        = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ped_btn,
  input  logic             side_req,
  output logic             step,
  output phase_t           phase,
  output logic [CNT_W-1:0] remain,
  output logic             ped_pending
);

  localparam int unsigned T_MAX = (1 << CNT_W) - 1;
  localparam int unsigned DURS [5] = '{T_GREEN_MAIN, T_YELLOW, T_ALLRED, T_GREEN_SIDE, T_PED};

  for (genvar gi = 0; gi < 5; gi++) begin : g_dur_chk
    if (DURS[gi] == 0 || DURS[gi] > T_MAX) begin : g_bad
      $error("traffic_phase_scheduler: duration %0d outside 1..%0d", DURS[gi], T_MAX);
    end
  end

  logic tick;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick)
  );

  logic ped_s1_q, ped_s2_q, ped_prev_q;
  logic side_s1_q, side_s2_q;

  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             step_q, step_d;
  logic             ped_pending_q, ped_pending_d;

  logic ped_rise;
  logic demand;
  logic enter_ped;

  assign ped_rise = ped_s2_q & ~ped_prev_q;
  assign demand   = side_s2_q | ped_pending_q;

  always_comb begin
    phase_d   = phase_q;
    remain_d  = remain_q;
    step_d    = 1'b0;
    enter_ped = 1'b0;

    if (3'(phase_q) == 3'b111) begin
      // Corrupted state recovers to main green as a fresh phase.
      phase_d  = GR;
      remain_d = CNT_W'(T_GREEN_MAIN);
      step_d   = 1'b1;
    end else if (tick) begin
      if (remain_q > CNT_W'(1)) begin
        remain_d = remain_q - CNT_W'(1);
      end else if (phase_q != GR || demand) begin
        phase_d   = next_phase(phase_q, ped_pending_q);
        remain_d  = CNT_W'(phase_duration(phase_d, T_GREEN_MAIN, T_YELLOW,
                                          T_ALLRED, T_GREEN_SIDE, T_PED));
        step_d    = 1'b1;
        enter_ped = (phase_d == PED);
      end
    end
  end

  // Entering PED serves the request, even one whose edge arrives this cycle.
  always_comb begin
    ped_pending_d = ped_pending_q;
    if (enter_ped) begin
      ped_pending_d = 1'b0;
    end else if (ped_rise) begin
      ped_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ped_s1_q      <= 1'b0;
      ped_s2_q      <= 1'b0;
      ped_prev_q    <= 1'b0;
      side_s1_q     <= 1'b0;
      side_s2_q     <= 1'b0;
      phase_q       <= GR;
      remain_q      <= CNT_W'(T_GREEN_MAIN);
      step_q        <= 1'b0;
      ped_pending_q <= 1'b0;
    end else begin
      ped_s1_q      <= ped_btn;
      ped_s2_q      <= ped_s1_q;
      ped_prev_q    <= ped_s2_q;
      side_s1_q     <= side_req;
      side_s2_q     <= side_s1_q;
      phase_q       <= phase_d;
      remain_q      <= remain_d;
      step_q        <= step_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  assign step        = step_q;
  assign phase       = phase_q;
  assign remain      = remain_q;
  assign ped_pending = ped_pending_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench: directed phase-sequence table, corner sequences and
// randomized traffic checked every cycle against a seconds-level model.
module tb_traffic_phase_scheduler;
  import traffic_pkg::*;

  localparam int TICK_DIV     = 4;
  localparam int CNT_W        = 4;
  localparam int T_GREEN_MAIN = 3;
  localparam int T_YELLOW     = 2;
  localparam int T_ALLRED     = 1;
  localparam int T_GREEN_SIDE = 2;
  localparam int T_PED        = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             ped_btn = 1'b0;
  logic             side_req = 1'b0;
  logic             step;
  phase_t           phase;
  logic [CNT_W-1:0] remain;
  logic             ped_pending;

  traffic_phase_scheduler #(
    .TICK_DIV(TICK_DIV), .CNT_W(CNT_W), .T_GREEN_MAIN(T_GREEN_MAIN),
    .T_YELLOW(T_YELLOW), .T_ALLRED(T_ALLRED), .T_GREEN_SIDE(T_GREEN_SIDE),
    .T_PED(T_PED)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ped_btn(ped_btn), .side_req(side_req),
    .step(step), .phase(phase), .remain(remain), .ped_pending(ped_pending)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: seconds-level view of the intersection.
  int     m_edges;
  bit     m_hped[3];
  bit     m_hside[3];
  phase_t m_ph;
  int     m_rem;
  bit     m_step;
  bit     m_pend;

  function automatic int dur_of(phase_t p);
    if (p == YR || p == RY) return T_YELLOW;
    if (p == RR1 || p == RR2) return T_ALLRED;
    if (p == RG) return T_GREEN_SIDE;
    if (p == PED) return T_PED;
    return T_GREEN_MAIN;
  endfunction

  task automatic model_reset();
    m_edges = 0;
    m_hped  = '{0, 0, 0};
    m_hside = '{0, 0, 0};
    m_ph    = GR;
    m_rem   = T_GREEN_MAIN;
    m_step  = 0;
    m_pend  = 0;
  endtask

  task automatic model_edge();
    bit tick, rise, side_now, new_step, serve;
    phase_t nxt;
    if (!reset_n) begin
      model_reset();
      return;
    end
    tick     = (m_edges % TICK_DIV) == TICK_DIV - 1;
    side_now = m_hside[1];
    rise     = m_hped[1] && !m_hped[2];
    new_step = 0;
    serve    = 0;
    if (tick) begin
      if (m_rem > 1) begin
        m_rem = m_rem - 1;
      end else if (!(m_ph == GR && !side_now && !m_pend)) begin
        if (m_ph == RR2) nxt = m_pend ? PED : GR;
        else if (m_ph == PED) nxt = GR;
        else nxt = phase_t'(int'(m_ph) + 1);
        m_ph     = nxt;
        m_rem    = dur_of(nxt);
        new_step = 1;
        serve    = (nxt == PED);
      end
    end
    if (serve) m_pend = 0;
    else if (rise) m_pend = 1;
    m_step     = new_step;
    m_hped[2]  = m_hped[1];
    m_hped[1]  = m_hped[0];
    m_hped[0]  = ped_btn;
    m_hside[2] = m_hside[1];
    m_hside[1] = m_hside[0];
    m_hside[0] = side_req;
    m_edges++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    vectors++;
    if (phase !== m_ph || remain !== CNT_W'(m_rem) || step !== m_step ||
        ped_pending !== m_pend) begin
      miscompares++;
      $display("FAIL model: phase=%0d remain=%0d step=%0d pend=%0d expected %0d/%0d/%0d/%0d at %0t",
               int'(phase), remain, step, ped_pending, int'(m_ph), m_rem, m_step, m_pend, $time);
    end
  endtask

  // Called between cycles; reset is applied away from any clock edge.
  task automatic async_reset(input bit check);
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    if (check) begin
      chk("rst_phase", int'(phase), int'(GR));
      chk("rst_remain", int'(remain), T_GREEN_MAIN);
      chk("rst_step", int'(step), 0);
      chk("rst_pend", int'(ped_pending), 0);
    end
    cycle();
    reset_n = 1'b1;
  endtask

  task automatic wait_step(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (step !== 1'b1 && n < 300);
    if (n >= 300) chk("step_timeout", n, 0);
  endtask

  task automatic wait_phase(input phase_t target);
    int n = 0;
    while (phase !== target && n < 300) begin
      cycle();
      n++;
    end
    if (n >= 300) chk("phase_timeout", int'(phase), int'(target));
  endtask

  typedef struct {
    phase_t ph;
    int     dur;
  } seq_vec_t;

  seq_vec_t seq_tbl[7];

  initial begin
    int n, exp_n, r, e, peds;
    seq_tbl[0] = '{GR, 3};
    seq_tbl[1] = '{YR, 2};
    seq_tbl[2] = '{RR1, 1};
    seq_tbl[3] = '{RG, 2};
    seq_tbl[4] = '{RY, 2};
    seq_tbl[5] = '{RR2, 1};
    seq_tbl[6] = '{GR, 3};

    model_reset();
    side_req = 1'b1;
    #1;
    cycle();
    cycle();
    reset_n = 1'b1;

    // Continuous side demand: full sequence with exact durations.
    for (int i = 0; i < 7; i++) begin
      chk("seq_phase", int'(phase), int'(seq_tbl[i].ph));
      chk("seq_remain", int'(remain), seq_tbl[i].dur);
      chk("seq_step", int'(step), (i == 0) ? 0 : 1);
      if (i < 6) begin
        wait_step(n);
        chk("seq_cycles", n, seq_tbl[i].dur * TICK_DIV);
      end
    end

    // No demand: main green rests at remain=1, then side demand releases it.
    side_req = 1'b0;
    peds = 0;
    for (int i = 0; i < 13 * TICK_DIV; i++) begin
      cycle();
      if (step) peds++;
    end
    chk("hold_steps", peds, 0);
    chk("hold_phase", int'(phase), int'(GR));
    chk("hold_remain", int'(remain), 1);
    for (int k = 0; k < 2; k++) begin
      repeat ($urandom_range(0, 3)) cycle();
      side_req = 1'b1;
      r = m_edges;
      e = r + 2;
      while (e % TICK_DIV != TICK_DIV - 1) e++;
      exp_n = e - r + 1;
      wait_step(n);
      chk("release_latency", n, exp_n);
      chk("release_phase", int'(phase), int'(YR));
      if (k == 0) begin
        side_req = 1'b0;
        wait_phase(GR);
        repeat (4 * TICK_DIV) cycle();
      end
    end

    // Walk request during side green.
    wait_phase(RG);
    ped_btn = 1'b1; cycle(); cycle();
    ped_btn = 1'b0; cycle(); cycle();
    chk("ped_latched", int'(ped_pending), 1);
    wait_phase(PED);
    chk("ped_entry_step", int'(step), 1);
    chk("ped_entry_clear", int'(ped_pending), 0);
    wait_step(n);
    chk("ped_cycles", n, T_PED * TICK_DIV);
    chk("ped_exit_phase", int'(phase), int'(GR));

    // Edge coinciding with PED entry is absorbed; a later press re-arms.
    wait_phase(RG);
    ped_btn = 1'b1; cycle(); cycle();
    ped_btn = 1'b0;
    wait_phase(RR2);
    cycle();
    ped_btn = 1'b1;
    wait_step(n);
    chk("coinc_phase", int'(phase), int'(PED));
    chk("coinc_pend", int'(ped_pending), 0);
    cycle();
    ped_btn = 1'b0; cycle(); cycle();
    ped_btn = 1'b1;
    repeat (4) cycle();
    chk("repress_pend", int'(ped_pending), 1);
    chk("repress_phase", int'(phase), int'(PED));
    ped_btn = 1'b0;
    wait_phase(RR2);
    wait_step(n);
    chk("repeat_ped", int'(phase), int'(PED));

    // Asynchronous reset in the middle of side green.
    wait_phase(RG);
    cycle(); cycle();
    async_reset(1'b1);

    // Held button: exactly one walk phase.
    ped_btn = 1'b1;
    peds = 0;
    for (int i = 0; i < 140; i++) begin
      if (i == 70) ped_btn = 1'b0;
      cycle();
      if (step && phase == PED) peds++;
    end
    chk("held_ped_once", peds, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) side_req = ~side_req;
      if ($urandom_range(0, 11) == 0) ped_btn = ~ped_btn;
      if ($urandom_range(0, 599) == 0) async_reset(1'b1);
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
